tdm_demux: RTL and testbench

- Time-division demultiplexer: the receive end of the mux path.
- Accepts a serialized stream of per-channel samples with a start-of-frame marker and distributes consecutive samples to N_CH channel slots.
- Presents each completed frame as one parallel word with a valid/ready handshake.
- Sits downstream of a TDM multiplexer and upstream of per-channel consumers.

---
 rtl/tdm_demux.sv | 125 ++++++++++++
 tb/tb_tdm_demux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a TDM link.
// Serial per-channel samples framed by an in_sof marker are gathered into
// shadow slots and handed out as one parallel frame over a valid/ready port.
// Optional build macro TDM_DEMUX_FRAME_CNT_EN adds a 16-bit delivered-frame
// counter output (frame_cnt).
module tdm_demux #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  err_sync
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                       state, state_nxt;
    logic [N_CH-1:0][WIDTH-1:0]   shadow;
    logic [N_CH-1:0][WIDTH-1:0]   frame;
    logic                         acc, last;
    logic                         do_first, do_store, do_done, do_early;

    // The only stall: final sample would complete a frame while the previous
    // one is still waiting on the consumer.
    assign last     = (cur_sel == SEL_W'(N_CH - 1));
    assign in_ready = !(state == COLLECT && last && out_valid && !out_ready);
    assign acc      = in_valid && in_ready;

    // Completed frame: stored slots plus the sample arriving this cycle on top.
    always_comb begin
        frame         = shadow;
        frame[N_CH-1] = in_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        do_first  = 1'b0;
        do_store  = 1'b0;
        do_done   = 1'b0;
        do_early  = 1'b0;
        case (state)
            IDLE: begin
                // Samples before the first marker carry no channel alignment.
                if (acc && in_sof) begin
                    do_first  = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (acc) begin
                    if (in_sof) begin
                        // Restart on an early marker; earlier slots get overwritten.
                        do_first = 1'b1;
                        do_early = 1'b1;
                    end else if (last) begin
                        do_done   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        do_store = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow slots, channel pointer, output frame register and sync error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            cur_sel   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            err_sync <= do_early;
            if (do_first) begin
                shadow[0] <= in_data;
                cur_sel   <= SEL_W'(1);
            end
            if (do_store) begin
                shadow[cur_sel] <= in_data;
                cur_sel         <= cur_sel + SEL_W'(1);
            end
            // A completing frame wins over delivery so back-to-back frames
            // keep out_valid high with no bubble.
            if (do_done) begin
                out_data  <= frame;
                out_valid <= 1'b1;
                cur_sel   <= '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    // Delivered-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst)                         frame_cnt <= 16'd0;
        else if (out_valid && out_ready) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed vector table plus hand-written sequences for
// tdm_demux with WIDTH=8, N_CH=4.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_sof, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, err_sync;
    logic [31:0] out_data;
    logic [1:0]  cur_sel;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(8), .N_CH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cur_sel(cur_sel),
        .err_sync(err_sync)
`ifdef TDM_DEMUX_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    typedef struct {
        logic        rst, v, sof;
        logic [7:0]  d;
        logic        ordy;
        logic        chk_rdy;
        logic        rdy;   // in_ready before the edge
        logic        ov;    // outputs after the edge
        logic [31:0] od;
        logic [1:0]  sel;
        logic        err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic s, input logic [7:0] d,
                       input logic o, input logic cr, input logic rdy, input logic ov,
                       input logic [31:0] od, input logic [1:0] sel, input logic err);
        vec_t x;
        x.rst = r; x.v = v; x.sof = s; x.d = d; x.ordy = o; x.chk_rdy = cr;
        x.rdy = rdy; x.ov = ov; x.od = od; x.sel = sel; x.err = err;
        vt.push_back(x);
    endtask

    // Drive one cycle of inputs; no checks.
    task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d, input logic o);
        rst = r; in_valid = v; in_sof = s; in_data = d; out_ready = o;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        #1;

        //   rst v sof data ordy chk rdy ov  out_data      sel  err
        // reset with an active stream
        add(1, 1, 0, 8'h55, 1, 0, 1, 0, 32'h00000000, 2'd0, 0);
        add(1, 1, 1, 8'h66, 1, 1, 1, 0, 32'h00000000, 2'd0, 0);
        // basic frame
        add(0, 1, 1, 8'h11, 1, 1, 1, 0, 32'h00000000, 2'd1, 0);
        add(0, 1, 0, 8'h22, 1, 1, 1, 0, 32'h00000000, 2'd2, 0);
        add(0, 1, 0, 8'h33, 1, 1, 1, 0, 32'h00000000, 2'd3, 0);
        add(0, 1, 0, 8'h44, 1, 1, 1, 1, 32'h44332211, 2'd0, 0);
        // pre-sync drop
        add(0, 1, 0, 8'hAA, 1, 1, 1, 0, 32'h44332211, 2'd0, 0);
        add(0, 1, 0, 8'hBB, 1, 1, 1, 0, 32'h44332211, 2'd0, 0);
        add(0, 1, 1, 8'h01, 1, 1, 1, 0, 32'h44332211, 2'd1, 0);
        add(0, 1, 0, 8'h02, 1, 1, 1, 0, 32'h44332211, 2'd2, 0);
        add(0, 1, 0, 8'h03, 1, 1, 1, 0, 32'h44332211, 2'd3, 0);
        add(0, 1, 0, 8'h04, 1, 1, 1, 1, 32'h04030201, 2'd0, 0);
        // early sync
        add(0, 1, 1, 8'h10, 1, 1, 1, 0, 32'h04030201, 2'd1, 0);
        add(0, 1, 0, 8'h20, 1, 1, 1, 0, 32'h04030201, 2'd2, 0);
        add(0, 1, 1, 8'h30, 1, 1, 1, 0, 32'h04030201, 2'd1, 1);
        add(0, 1, 0, 8'h40, 1, 1, 1, 0, 32'h04030201, 2'd2, 0);
        add(0, 1, 0, 8'h50, 1, 1, 1, 0, 32'h04030201, 2'd3, 0);
        add(0, 1, 0, 8'h60, 1, 1, 1, 1, 32'h60504030, 2'd0, 0);
        add(0, 0, 0, 8'h00, 1, 1, 1, 0, 32'h60504030, 2'd0, 0);
        // backpressure with two back-to-back frames
        add(0, 1, 1, 8'h01, 0, 1, 1, 0, 32'h60504030, 2'd1, 0);
        add(0, 1, 0, 8'h02, 0, 1, 1, 0, 32'h60504030, 2'd2, 0);
        add(0, 1, 0, 8'h03, 0, 1, 1, 0, 32'h60504030, 2'd3, 0);
        add(0, 1, 0, 8'h04, 0, 1, 1, 1, 32'h04030201, 2'd0, 0);
        add(0, 1, 1, 8'h05, 0, 1, 1, 1, 32'h04030201, 2'd1, 0);
        add(0, 1, 0, 8'h06, 0, 1, 1, 1, 32'h04030201, 2'd2, 0);
        add(0, 1, 0, 8'h07, 0, 1, 1, 1, 32'h04030201, 2'd3, 0);
        add(0, 1, 0, 8'h08, 0, 1, 0, 1, 32'h04030201, 2'd3, 0);
        add(0, 1, 0, 8'h08, 0, 1, 0, 1, 32'h04030201, 2'd3, 0);
        add(0, 1, 0, 8'h08, 1, 1, 1, 1, 32'h08070605, 2'd0, 0);
        add(0, 0, 0, 8'h00, 1, 1, 1, 0, 32'h08070605, 2'd0, 0);
        // reset mid-frame
        add(0, 1, 1, 8'h0A, 1, 1, 1, 0, 32'h08070605, 2'd1, 0);
        add(0, 1, 0, 8'h0B, 1, 1, 1, 0, 32'h08070605, 2'd2, 0);
        add(1, 1, 0, 8'h0C, 1, 1, 1, 0, 32'h00000000, 2'd0, 0);
        add(0, 1, 0, 8'h0D, 1, 1, 1, 0, 32'h00000000, 2'd0, 0);
        // reset clears a pending frame
        add(0, 1, 1, 8'h01, 0, 1, 1, 0, 32'h00000000, 2'd1, 0);
        add(0, 1, 0, 8'h02, 0, 1, 1, 0, 32'h00000000, 2'd2, 0);
        add(0, 1, 0, 8'h03, 0, 1, 1, 0, 32'h00000000, 2'd3, 0);
        add(0, 1, 0, 8'h04, 0, 1, 1, 1, 32'h04030201, 2'd0, 0);
        add(1, 0, 0, 8'h00, 0, 1, 1, 0, 32'h00000000, 2'd0, 0);
        // early sync in the last slot
        add(0, 1, 1, 8'h11, 1, 1, 1, 0, 32'h00000000, 2'd1, 0);
        add(0, 1, 0, 8'h22, 1, 1, 1, 0, 32'h00000000, 2'd2, 0);
        add(0, 1, 0, 8'h33, 1, 1, 1, 0, 32'h00000000, 2'd3, 0);
        add(0, 1, 1, 8'h99, 1, 1, 1, 0, 32'h00000000, 2'd1, 1);
        add(0, 1, 0, 8'hAA, 1, 1, 1, 0, 32'h00000000, 2'd2, 0);
        add(0, 1, 0, 8'hBB, 1, 1, 1, 0, 32'h00000000, 2'd3, 0);
        add(0, 1, 0, 8'hCC, 1, 1, 1, 1, 32'hCCBBAA99, 2'd0, 0);

        foreach (vt[i]) begin
            rst = vt[i].rst; in_valid = vt[i].v; in_sof = vt[i].sof;
            in_data = vt[i].d; out_ready = vt[i].ordy;
            #1;
            if (vt[i].chk_rdy) chk("in_ready", i, 32'(in_ready), 32'(vt[i].rdy));
            @(posedge clk); #1;
            chk("out_valid", i, 32'(out_valid), 32'(vt[i].ov));
            chk("out_data",  i, out_data,       vt[i].od);
            chk("cur_sel",   i, 32'(cur_sel),   32'(vt[i].sel));
            chk("err_sync",  i, 32'(err_sync),  32'(vt[i].err));
        end

        // sustained back-to-back frames with out_ready high: no bubble
        drive(1, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 8'h01, 1);
        drive(0, 1, 0, 8'h02, 1);
        drive(0, 1, 0, 8'h03, 1);
        drive(0, 1, 0, 8'h04, 1);
        chk("b2b_ov1", 100, 32'(out_valid), 32'd1);
        chk("b2b_od1", 100, out_data, 32'h04030201);
        drive(0, 1, 1, 8'h05, 1);
        drive(0, 1, 0, 8'h06, 1);
        drive(0, 1, 0, 8'h07, 1);
        chk("b2b_rdy", 101, 32'(in_ready), 32'd1);
        drive(0, 1, 0, 8'h08, 1);
        chk("b2b_ov2", 101, 32'(out_valid), 32'd1);
        chk("b2b_od2", 101, out_data, 32'h08070605);
        drive(0, 0, 0, 8'h00, 1);
        chk("b2b_drain", 102, 32'(out_valid), 32'd0);

`ifdef TDM_DEMUX_FRAME_CNT_EN
        // counter: three delivered frames, reset mid-frame, one more frame
        drive(1, 0, 0, 8'h00, 1);
        chk("cnt_rst0", 200, 32'(frame_cnt), 32'd0);
        for (int f = 0; f < 3; f++) begin
            drive(0, 1, 1, 8'h01, 1);
            drive(0, 1, 0, 8'h02, 1);
            drive(0, 1, 0, 8'h03, 1);
            drive(0, 1, 0, 8'h04, 1);
        end
        drive(0, 0, 0, 8'h00, 1);
        chk("cnt_three", 201, 32'(frame_cnt), 32'd3);
        drive(0, 1, 1, 8'hE1, 1);
        drive(0, 1, 0, 8'hE2, 1);
        drive(1, 1, 0, 8'hE3, 1);
        chk("cnt_rst", 202, 32'(frame_cnt), 32'd0);
        chk("cnt_sel", 202, 32'(cur_sel), 32'd0);
        chk("cnt_ov",  202, 32'(out_valid), 32'd0);
        drive(0, 1, 1, 8'hA1, 1);
        drive(0, 1, 0, 8'hA2, 1);
        drive(0, 1, 0, 8'hA3, 1);
        drive(0, 1, 0, 8'hA4, 1);
        chk("cnt_od", 203, out_data, 32'hA4A3A2A1);
        drive(0, 0, 0, 8'h00, 1);
        chk("cnt_one", 203, 32'(frame_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
